// File: rtl/vec_pipe_pkg.sv
// vec_pipe_pkg: shared fetch/decode types, default constants and a width helper.
package vec_pipe_pkg;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_STEP = 4;
    typedef logic [DEF_ADDR_W-1:0]  addr_t;
    typedef logic [DEF_INSTR_W-1:0] instr_t;
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/vec_ifid_fifo.sv
// vec_ifid_fifo: circular instruction queue; clear outranks push/pop, any DEPTH >= 2.
module vec_ifid_fifo
    import vec_pipe_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int CW    = clog2(DEPTH + 1),
    localparam int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              head,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] rd_q, wr_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            count <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= din;
                wr_q      <= nxt(wr_q);
            end
            if (pop) rd_q <= nxt(rd_q);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_q];
endmodule

// File: rtl/vec_fetch_ifid.sv
// vec_fetch_ifid: PC/fetch issue into a 1-cycle imem plus an IF/ID queue with
// back-pressure, halt and redirect.
module vec_fetch_ifid
    import vec_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               busy
);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;
    localparam int CW = clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, inflight_pc_q;
    logic              inflight_q, issue, push, pop;
    logic [CW-1:0]     count;
    entry_t            head, din;

    // Credit: queued plus in-flight entries may not exceed DEPTH, counting this cycle's pop.
    assign pop      = id_valid & id_ready;
    assign push     = inflight_q & !redirect_valid;
    assign issue    = !rst & !halt & !redirect_valid &
                      (int'(count) + int'(inflight_q) < DEPTH + int'(pop));
    assign id_valid = (count != '0) & !redirect_valid;
    assign busy     = (count != '0) | inflight_q;
    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign din       = '{instr: imem_rdata, pc: inflight_pc_q};
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
            pc_q <= redirect_valid ? redirect_pc : issue ? pc_q + ADDR_W'(PC_STEP) : pc_q;
        end
    end

    vec_ifid_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_vec_fetch_ifid.sv
// tb_vec_fetch_ifid: table-driven per-cycle checks of two configurations
// (DEPTH=2 from PC 0, DEPTH=3 from PC 0xFFFF_FFF8).
module tb_vec_fetch_ifid;
    typedef struct {
        logic        rst, halt, redir;
        logic [31:0] rpc;
        logic        ready, en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1, halt = 1'b0, redir = 1'b0, ready = 1'b1;
    logic [31:0] rpc = '0;
    logic        en0, en1, valid0, valid1, busy0, busy1;
    logic [31:0] addr0, addr1, rdata0, rdata1, instr0, instr1, pc0, pc1;
    int          checks = 0, fails = 0;
    vec_t        q0[$], q1[$];

    always #5 clk = ~clk;

    vec_fetch_ifid #(.DEPTH(2)) u0 (
        .clk(clk), .rst(rst0), .imem_en(en0), .imem_addr(addr0), .imem_rdata(rdata0),
        .halt(halt), .redirect_valid(redir), .redirect_pc(rpc), .id_valid(valid0),
        .id_ready(ready), .id_instr(instr0), .id_pc(pc0), .busy(busy0)
    );
    vec_fetch_ifid #(.DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst1), .imem_en(en1), .imem_addr(addr1), .imem_rdata(rdata1),
        .halt(halt), .redirect_valid(redir), .redirect_pc(rpc), .id_valid(valid1),
        .id_ready(ready), .id_instr(instr1), .id_pc(pc1), .busy(busy1)
    );

    // Instruction memory: word at byte address A reads as 0x1000_0000 + A.
    always @(posedge clk) begin
        if (en0) rdata0 <= 32'h1000_0000 + addr0;
        if (en1) rdata1 <= 32'h1000_0000 + addr1;
    end

    always @(negedge clk) begin
        if (!rst0) assert (!(u0.push && int'(u0.count) == 2)) else $error("FAIL overflow u0 push into full queue");
        if (!rst1) assert (!(u1.push && int'(u1.count) == 3)) else $error("FAIL overflow u1 push into full queue");
    end

    function automatic vec_t mk(input logic r, h, d, input logic [31:0] p, input logic rd, e,
                                input logic [31:0] a, input logic v, input logic [31:0] ip,
                                input logic b);
        vec_t x;
        x = '{rst: r, halt: h, redir: d, rpc: p, ready: rd, en: e, addr: a, valid: v, pc: ip, busy: b};
        return x;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit s, input int cyc);
        @(negedge clk);
        if (s) rst1 = v.rst;
        else rst0 = v.rst;
        halt  = v.halt;
        redir = v.redir;
        rpc   = v.rpc;
        ready = v.ready;
        #1;
        check(s ? "u1.imem_en" : "u0.imem_en", cyc, 32'(s ? en1 : en0), 32'(v.en));
        check(s ? "u1.id_valid" : "u0.id_valid", cyc, 32'(s ? valid1 : valid0), 32'(v.valid));
        check(s ? "u1.busy" : "u0.busy", cyc, 32'(s ? busy1 : busy0), 32'(v.busy));
        if (v.en) check(s ? "u1.imem_addr" : "u0.imem_addr", cyc, s ? addr1 : addr0, v.addr);
        if (v.valid) begin
            check(s ? "u1.id_pc" : "u0.id_pc", cyc, s ? pc1 : pc0, v.pc);
            check(s ? "u1.id_instr" : "u0.id_instr", cyc, s ? instr1 : instr0, 32'h1000_0000 + v.pc);
        end
    endtask

    initial begin
        // DEPTH=2: startup, 5-cycle stall, redirect with full queue, halt, reset mid-run
        q0.push_back(mk(0,0,0,0,1, 1,32'h000, 0,0,0));
        q0.push_back(mk(0,0,0,0,1, 1,32'h004, 0,0,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h008, 1,32'h000,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h00C, 1,32'h004,1));
        for (int i = 0; i < 5; i++) q0.push_back(mk(0,0,0,0,0, 0,0, 1,32'h008,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h010, 1,32'h008,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h014, 1,32'h00C,1));
        q0.push_back(mk(0,0,0,0,0, 0,0, 1,32'h010,1));
        q0.push_back(mk(0,0,1,32'h100,1, 0,0, 0,0,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h100, 0,0,0));
        q0.push_back(mk(0,0,0,0,1, 1,32'h104, 0,0,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h108, 1,32'h100,1));
        q0.push_back(mk(0,1,0,0,1, 0,0, 1,32'h104,1));
        q0.push_back(mk(0,1,0,0,1, 0,0, 1,32'h108,1));
        q0.push_back(mk(0,1,0,0,1, 0,0, 0,0,0));
        q0.push_back(mk(0,1,0,0,1, 0,0, 0,0,0));
        q0.push_back(mk(0,0,0,0,1, 1,32'h10C, 0,0,0));
        q0.push_back(mk(0,0,0,0,1, 1,32'h110, 0,0,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h114, 1,32'h10C,1));
        q0.push_back(mk(1,0,0,0,0, 0,0, 1,32'h110,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h000, 0,0,0));
        q0.push_back(mk(0,0,0,0,1, 1,32'h004, 0,0,1));
        q0.push_back(mk(0,0,0,0,1, 1,32'h008, 1,32'h000,1));
        // DEPTH=3 from 0xFFFF_FFF8: wrap, stall, redirect with read in flight, back-to-back redirect + halt
        q1.push_back(mk(0,0,0,0,1, 1,32'hFFFF_FFF8, 0,0,0));
        q1.push_back(mk(0,0,0,0,1, 1,32'hFFFF_FFFC, 0,0,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h0000_0000, 1,32'hFFFF_FFF8,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h0000_0004, 1,32'hFFFF_FFFC,1));
        q1.push_back(mk(0,0,0,0,0, 1,32'h0000_0008, 1,32'h0000_0000,1));
        for (int i = 0; i < 4; i++) q1.push_back(mk(0,0,0,0,0, 0,0, 1,32'h0,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h00C, 1,32'h000,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h010, 1,32'h004,1));
        q1.push_back(mk(0,0,1,32'h200,1, 0,0, 0,0,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h200, 0,0,0));
        q1.push_back(mk(0,0,0,0,1, 1,32'h204, 0,0,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h208, 1,32'h200,1));
        q1.push_back(mk(0,0,1,32'h300,1, 0,0, 0,0,1));
        q1.push_back(mk(0,1,1,32'h400,1, 0,0, 0,0,0));
        q1.push_back(mk(0,1,0,0,1, 0,0, 0,0,0));
        q1.push_back(mk(0,0,0,0,1, 1,32'h400, 0,0,0));
        q1.push_back(mk(0,0,0,0,1, 1,32'h404, 0,0,1));
        q1.push_back(mk(0,0,0,0,1, 1,32'h408, 1,32'h400,1));

        repeat (2) @(negedge clk);
        #1;
        check("rst u0.imem_en", -1, 32'(en0), 0);
        check("rst u0.id_valid", -1, 32'(valid0), 0);
        check("rst u0.busy", -1, 32'(busy0), 0);
        check("rst u0.id_instr", -1, instr0, 0);
        check("rst u0.id_pc", -1, pc0, 0);
        check("rst u0.imem_addr", -1, addr0, 0);
        check("rst u1.imem_addr", -1, addr1, 32'hFFFF_FFF8);
        foreach (q0[i]) apply(q0[i], 1'b0, i);
        rst0 = 1'b1;
        foreach (q1[i]) apply(q1[i], 1'b1, i);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
